// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: programmable clk divider producing a sampling tick that paces one ADC frame.
// Latency: o_tick 1 cycle after counter wrap; o_adc_start 1 cycle after o_tick; o_frame_done 1 cycle after last done.
// Backpressure: WAIT holds for i_adc_done indefinitely; ticks landing in a running frame are dropped and flagged sticky.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   i_enable         1 = counter runs and ticks are generated; 0 = counter held at 0
//   i_period         requested period in clk cycles (values below 2 are clamped to 2)
//   i_period_load    strobe capturing i_period into the shadow register
//   i_adc_done       ADC interface pulse: current channel converted
//   i_ovr_clr        clears o_overrun (a coincident overrun set takes priority)
//   o_tick           one-cycle sampling tick
//   o_adc_start      one-cycle conversion request for channel o_adc_ch
//   o_adc_ch         channel index, held until the matching done
//   o_frame_done     one-cycle pulse after the last channel's done
//   o_busy           frame in progress
//   o_overrun        sticky: a tick arrived while a frame was running
module adc_sample_scheduler #(
  parameter int                    NB_COUNTER    = 11,
  parameter logic [NB_COUNTER-1:0] COUNT_LIM_DEF = 11'd900,
  parameter int                    N_CH          = 3,
  parameter int                    NB_CH         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [NB_COUNTER-1:0] i_period,
  input  logic                  i_period_load,
  input  logic                  i_adc_done,
  input  logic                  i_ovr_clr,
  output logic                  o_tick,
  output logic                  o_adc_start,
  output logic [NB_CH-1:0]      o_adc_ch,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam logic [NB_COUNTER-1:0] CNT_ONE    = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] PERIOD_MIN = NB_COUNTER'(2);
  localparam logic [NB_CH-1:0]      CH_ONE     = NB_CH'(1);
  localparam logic [NB_CH-1:0]      LAST_CH    = NB_CH'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Period registers and tick counter
  // ---------------------------------------------------------------------------
  logic [NB_COUNTER-1:0] counter;
  logic [NB_COUNTER-1:0] active_period;
  logic [NB_COUNTER-1:0] shadow_period;
  logic [NB_COUNTER-1:0] period_req;
  logic                  shadow_vld;
  logic                  wrap;
  logic                  xfer;

  // A period of 1 would make the counter compare against 0 forever; 2 is the floor.
  assign period_req = (i_period < PERIOD_MIN) ? PERIOD_MIN : i_period;

  assign wrap = i_enable && (counter == (active_period - CNT_ONE));

  // The shadow only moves into the active period on a wrap so the running interval
  // is never cut short; with the counter stopped there is no wrap to wait for.
  assign xfer = shadow_vld && (wrap || !i_enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      o_tick  <= 1'b0;
    end else if (wrap) begin
      counter <= '0;
      o_tick  <= 1'b1;
    end else if (i_enable) begin
      counter <= counter + CNT_ONE;
      o_tick  <= 1'b0;
    end else begin
      counter <= '0;
      o_tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_period <= COUNT_LIM_DEF;
      shadow_period <= '0;
      shadow_vld    <= 1'b0;
    end else begin
      if (xfer) begin
        active_period <= shadow_period;
      end
      // A load in the same cycle as a transfer stays pending for the next one.
      if (i_period_load) begin
        shadow_period <= period_req;
        shadow_vld    <= 1'b1;
      end else if (xfer) begin
        shadow_vld    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [NB_CH-1:0] channel;
  logic             last_done;

  assign last_done = (state == WAIT) && i_adc_done && (channel == LAST_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (o_tick) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (i_adc_done) begin
          state_nxt = (channel == LAST_CH) ? IDLE : START;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_adc_start = (state == START);
    o_busy      = (state != IDLE);
    o_adc_ch    = channel;
  end

  // Channel index is held through WAIT so the ADC side sees a stable index
  // until it answers; it is only rewound when a new frame is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      channel <= '0;
    end else if ((state == IDLE) && o_tick) begin
      channel <= '0;
    end else if ((state == WAIT) && i_adc_done && (channel != LAST_CH)) begin
      channel <= channel + CH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= last_done;
    end
  end

  // The state register is still WAIT in the cycle of the final done, so a tick
  // coinciding with it is treated as colliding with the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overrun <= 1'b0;
    end else if (o_tick && (state != IDLE)) begin
      o_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed bench for adc_sample_scheduler.
// Latency: n/a (bench).
// Backpressure: n/a (bench); the ADC responder answers a start after a programmable delay.
module tb_adc_sample_scheduler;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic [10:0] i_period;
  logic        i_period_load;
  logic        man_done;
  logic        adc_done_m;
  logic        i_ovr_clr;
  logic        o_tick;
  logic        o_adc_start;
  logic [1:0]  o_adc_ch;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_overrun;
  wire         i_adc_done = man_done | adc_done_m;

  adc_sample_scheduler #(
    .NB_COUNTER   (11),
    .COUNT_LIM_DEF(11'd900),
    .N_CH         (3),
    .NB_CH        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_period     (i_period),
    .i_period_load(i_period_load),
    .i_adc_done   (i_adc_done),
    .i_ovr_clr    (i_ovr_clr),
    .o_tick       (o_tick),
    .o_adc_start  (o_adc_start),
    .o_adc_ch     (o_adc_ch),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_bad;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Event logger: cycle numbers of ticks and starts, started channels, frame_done count.
  int cyc;
  int tick_q[$];
  int start_cyc[$];
  int start_ch[$];
  int fdone_n;

  initial begin
    cyc     = 0;
    fdone_n = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #3;
      if (o_tick) tick_q.push_back(cyc);
      if (o_adc_start) begin
        start_cyc.push_back(cyc);
        start_ch.push_back(int'(o_adc_ch));
      end
      if (o_frame_done) fdone_n++;
    end
  end

  function automatic int tq(input int i);
    return (i < tick_q.size()) ? tick_q[i] : -99999;
  endfunction

  function automatic int sc(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -99999;
  endfunction

  function automatic int sh(input int i);
    return (i < start_ch.size()) ? start_ch[i] : -1;
  endfunction

  task automatic clear_logs();
    tick_q.delete();
    start_cyc.delete();
    start_ch.delete();
    fdone_n = 0;
  endtask

  // ADC responder: done pulses adc_delay cycles after a start is seen.
  logic adc_auto;
  int   adc_delay;
  int   adc_cnt;

  initial begin
    adc_done_m = 1'b0;
    adc_cnt    = 0;
    forever begin
      @(posedge clk);
      #2;
      adc_done_m = 1'b0;
      if (adc_auto) begin
        if (adc_cnt > 0) begin
          adc_cnt--;
          if (adc_cnt == 0) adc_done_m = 1'b1;
        end
        if (o_adc_start) adc_cnt = adc_delay;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_ticks(input string name, input int n, input int budget);
    int k;
    k = 0;
    while ((tick_q.size() < n) && (k < budget)) begin
      step();
      k++;
    end
    chk_b(name, tick_q.size() >= n, 1'b1);
  endtask

  task automatic load_period(input int p);
    i_period      = 11'(p);
    i_period_load = 1'b1;
    step();
    i_period_load = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_b({tag, ".tick"},  o_tick,       1'b0);
    chk_b({tag, ".start"}, o_adc_start,  1'b0);
    chk_i({tag, ".ch"},    int'(o_adc_ch), 0);
    chk_b({tag, ".fdone"}, o_frame_done, 1'b0);
    chk_b({tag, ".busy"},  o_busy,       1'b0);
    chk_b({tag, ".ovr"},   o_overrun,    1'b0);
  endtask

  // Per-cycle vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        en;
    logic        load;
    logic [10:0] period;
    logic        done;
    logic        clr;
    logic        tick;
    logic        start;
    logic [1:0]  ch;
    logic        fdone;
    logic        busy;
    logic        ovr;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input int en, input int load, input int period, input int done,
                              input int clr, input int tick, input int start, input int ch,
                              input int fdone, input int busy, input int ovr);
    vec_t v;
    v.en = 1'(en);     v.load = 1'(load);   v.period = 11'(period);
    v.done = 1'(done); v.clr = 1'(clr);     v.tick = 1'(tick);
    v.start = 1'(start); v.ch = 2'(ch);     v.fdone = 1'(fdone);
    v.busy = 1'(busy); v.ovr = 1'(ovr);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int c0;
  int k;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; i_enable = 1'b0; i_period = '0; i_period_load = 1'b0;
    man_done = 1'b0; i_ovr_clr = 1'b0; adc_auto = 1'b0; adc_delay = 5;

    //            en ld per dn clr | tk st ch fd bz ov
    vecs[0]  = mk(0, 1, 6, 0, 0,    0, 0, 0, 0, 0, 0);  // load with counter stopped
    vecs[1]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // shadow copied now
    vecs[2]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);  // 6th enabled edge: tick
    vecs[8]  = mk(1, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0);  // start ch0
    vecs[9]  = mk(1, 0, 0, 1, 0,    0, 0, 0, 0, 1, 0);  // done in START ignored
    vecs[10] = mk(1, 0, 0, 1, 0,    0, 1, 1, 0, 1, 0);  // start ch1
    vecs[11] = mk(1, 0, 0, 0, 0,    0, 0, 1, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 1, 0,    0, 1, 2, 0, 1, 0);  // start ch2
    vecs[13] = mk(1, 0, 0, 0, 0,    1, 0, 2, 0, 1, 0);  // tick while in WAIT
    vecs[14] = mk(1, 0, 0, 0, 1,    0, 0, 2, 0, 1, 1);  // overrun set beats clear
    vecs[15] = mk(1, 0, 0, 1, 1,    0, 0, 2, 1, 0, 0);  // final done; clear alone
    vecs[16] = mk(1, 0, 0, 1, 0,    0, 0, 2, 0, 0, 0);  // done in IDLE ignored
    vecs[17] = mk(1, 0, 0, 0, 0,    0, 0, 2, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 0,    0, 0, 2, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0,    1, 0, 2, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0);

    steps(3);
    chk_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      i_enable = vecs[i].en; i_period_load = vecs[i].load; i_period = vecs[i].period;
      man_done = vecs[i].done; i_ovr_clr = vecs[i].clr;
      step();
      chk_b($sformatf("vec%0d.tick", i),  o_tick,       vecs[i].tick);
      chk_b($sformatf("vec%0d.start", i), o_adc_start,  vecs[i].start);
      chk_i($sformatf("vec%0d.ch", i),    int'(o_adc_ch), int'(vecs[i].ch));
      chk_b($sformatf("vec%0d.fdone", i), o_frame_done, vecs[i].fdone);
      chk_b($sformatf("vec%0d.busy", i),  o_busy,       vecs[i].busy);
      chk_b($sformatf("vec%0d.ovr", i),   o_overrun,    vecs[i].ovr);
    end
    i_enable = 1'b0; i_period_load = 1'b0; man_done = 1'b0; i_ovr_clr = 1'b0;

    // Defaults, then a mid-period reload to 100.
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    adc_auto = 1'b1; adc_delay = 5;
    clear_logs();
    c0 = cyc;
    i_enable = 1'b1;
    wait_ticks("def.first_tick", 1, 1000);
    chk_i("def.first_tick_delay", tq(0) - c0, 900);
    steps(30);
    chk_i("def.starts", start_ch.size(), 3);
    chk_i("def.start_lat", sc(0) - tq(0), 1);
    chk_i("def.ch0", sh(0), 0);
    chk_i("def.ch1", sh(1), 1);
    chk_i("def.ch2", sh(2), 2);
    chk_i("def.fdone", fdone_n, 1);
    chk_b("def.ovr", o_overrun, 1'b0);
    load_period(100);
    wait_ticks("p100.ticks", 4, 1500);
    chk_i("p100.gap_cur", tq(1) - tq(0), 900);
    chk_i("p100.gap_new1", tq(2) - tq(1), 100);
    chk_i("p100.gap_new2", tq(3) - tq(2), 100);
    chk_i("p100.fdone", fdone_n, 3);
    chk_b("p100.ovr", o_overrun, 1'b0);

    // Clamped periods with the ADC responder running.
    load_period(0);
    wait_ticks("p0.ticks", 7, 200);
    chk_i("p0.gap1", tq(5) - tq(4), 2);
    chk_i("p0.gap2", tq(6) - tq(5), 2);
    chk_b("p0.ovr_set", o_overrun, 1'b1);
    k = 0;
    while (!(o_adc_start && o_busy) && (k < 50)) begin step(); k++; end
    chk_b("p0.found_start", o_adc_start, 1'b1);
    if (o_tick) step();
    i_ovr_clr = 1'b1;
    step();
    i_ovr_clr = 1'b0;
    chk_b("p0.ovr_cleared", o_overrun, 1'b0);
    step();
    chk_b("p0.ovr_reset", o_overrun, 1'b1);
    load_period(1);
    steps(6);
    clear_logs();
    wait_ticks("p1.ticks", 3, 20);
    chk_i("p1.gap1", tq(1) - tq(0), 2);
    chk_i("p1.gap2", tq(2) - tq(1), 2);

    // Period 20 with a slow ADC: ticks during WAIT are dropped.
    i_enable = 1'b0;
    k = 0;
    while (o_busy && (k < 300)) begin step(); k++; end
    chk_b("slow.idle", o_busy, 1'b0);
    adc_delay = 30;
    i_ovr_clr = 1'b1;
    load_period(20);
    i_ovr_clr = 1'b0;
    step();
    chk_b("slow.ovr_clr", o_overrun, 1'b0);
    clear_logs();
    c0 = cyc;
    i_enable = 1'b1;
    steps(118);
    chk_i("slow.first_tick", tq(0) - c0, 20);
    chk_i("slow.ticks", tick_q.size(), 5);
    chk_i("slow.starts", start_ch.size(), 3);
    chk_i("slow.start_lat", sc(0) - c0, 21);
    chk_i("slow.ch0", sh(0), 0);
    chk_i("slow.ch1", sh(1), 1);
    chk_i("slow.ch2", sh(2), 2);
    chk_i("slow.fdone", fdone_n, 1);
    chk_b("slow.ovr", o_overrun, 1'b1);

    // Disable while waiting on ch1: frame still completes, then silence.
    k = 0;
    while (!(o_adc_start && (o_adc_ch == 2'd1)) && (k < 100)) begin step(); k++; end
    chk_b("dis.found_ch1", o_adc_start, 1'b1);
    step();
    i_enable = 1'b0;
    step();
    clear_logs();
    k = 0;
    while ((fdone_n < 1) && (k < 200)) begin step(); k++; end
    chk_i("dis.fdone", fdone_n, 1);
    chk_i("dis.starts", start_ch.size(), 1);
    chk_i("dis.ch2", sh(0), 2);
    steps(50);
    chk_i("dis.no_ticks", tick_q.size(), 0);
    chk_i("dis.no_starts", start_ch.size(), 1);
    chk_b("dis.busy", o_busy, 1'b0);
    c0 = cyc;
    i_enable = 1'b1;
    wait_ticks("reen.tick", 1, 60);
    chk_i("reen.delay", tq(0) - c0, 20);

    // Reset in WAIT, then a stray done.
    k = 0;
    while (!(o_busy && !o_adc_start) && (k < 10)) begin step(); k++; end
    chk_b("rstw.in_wait", o_busy && !o_adc_start, 1'b1);
    adc_auto = 1'b0;
    rst = 1'b1;
    step();
    chk_outputs_zero("rstw");
    c0 = cyc;
    rst = 1'b0;
    man_done = 1'b1;
    clear_logs();
    step();
    man_done = 1'b0;
    steps(10);
    chk_i("rstw.no_start", start_ch.size(), 0);
    chk_i("rstw.no_fdone", fdone_n, 0);
    chk_b("rstw.busy", o_busy, 1'b0);
    wait_ticks("rstw.tick", 1, 1000);
    chk_i("rstw.period", tq(0) - c0, 900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
